// File: rtl/turn_arbiter.sv
// turn_arbiter: merges NES and bongo controller frames into one buffered turn request
// (lturn/rturn/uturn) plus a start pulse. Optional macro MIC_UTURN_EN: bongo mic level drives U-turn in rotation mode.
module turn_arbiter #(
  parameter int TIMEOUT_TICKS = 180,
  parameter int REQ_LIFE      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        mode,
  input  logic [1:0]  pacman_dir,
  input  logic [7:0]  nes_btns,
  input  logic        nes_valid,
  input  logic [15:0] bongo_btns,
  input  logic [7:0]  bongo_mic,
  input  logic        bongo_valid,
  input  logic        turn_ack,
  output logic        lturn,
  output logic        rturn,
  output logic        uturn,
  output logic        start,
  output logic [1:0]  active_src
);

  typedef enum logic [1:0] {IDLE = 2'b00, NES_ACT = 2'b01, BONGO_ACT = 2'b10} state_t;

  state_t      state_p1, state_nxt;
  logic [3:0]  nes_map_p0, bongo_map_p0, nes_edge_p0, bongo_edge_p0;
  logic [3:0]  nes_prev_p1, bongo_prev_p1;
  logic        nes_primed_p1, bongo_primed_p1;
  logic        mic_u_p0;
  logic        nes_go_p0, bongo_go_p0, nes_turn_ok_p0, bongo_turn_ok_p0;
  logic        act_press_p0, timeout_p0;
  logic [2:0]  turn_p0, buf_p1;
  logic [3:0]  life_p1;
  logic [7:0]  idle_cnt_p1;
  logic        btn_unused;

  // Absolute direction buttons to {u,l,r} relative to the current heading.
  function automatic logic [2:0] rel_map(input logic [1:0] dir, input logic up, input logic dn,
                                         input logic lt, input logic rt);
    logic [2:0] r;
    case (dir)
      2'b00:   r = {lt, up, dn};
      2'b01:   r = {dn, lt, rt};
      2'b10:   r = {up, rt, lt};
      default: r = {rt, dn, up};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] prio_turn(input logic [2:0] t);
    if (t[2]) return 3'b100;
    if (t[1]) return 3'b010;
    if (t[0]) return 3'b001;
    return 3'b000;
  endfunction

  assign btn_unused = ^{nes_btns[2], bongo_btns[2:0], bongo_btns[11:8]};

`ifdef MIC_UTURN_EN
  assign mic_u_p0 = (bongo_mic > 8'd64) &
                    ~(bongo_btns[4] | bongo_btns[6] | bongo_btns[5] | bongo_btns[7]);
`else
  logic mic_unused;
  assign mic_u_p0   = 1'b0;
  assign mic_unused = ^bongo_mic;
`endif

  // Stage p0: map raw frames to {start,u,l,r} and detect rising edges against history.
  always_comb begin
    nes_map_p0   = {nes_btns[3], 3'b000};
    bongo_map_p0 = {bongo_btns[3], 3'b000};
    if (mode) begin
      nes_map_p0[2:0]   = rel_map(pacman_dir, nes_btns[4], nes_btns[5], nes_btns[6], nes_btns[7]);
      bongo_map_p0[2:0] = rel_map(pacman_dir, bongo_btns[12], bongo_btns[13],
                                  bongo_btns[15], bongo_btns[14]);
    end else begin
      nes_map_p0[2:0]   = {nes_btns[5], nes_btns[1], nes_btns[0]};
      bongo_map_p0[2:0] = {mic_u_p0, bongo_btns[4] | bongo_btns[6], bongo_btns[5] | bongo_btns[7]};
    end
  end

  // The first frame after reset only seeds history, so a button held through reset never fires.
  assign nes_edge_p0   = (nes_valid && nes_primed_p1) ? (nes_map_p0 & ~nes_prev_p1) : 4'b0000;
  assign bongo_edge_p0 = (bongo_valid && bongo_primed_p1) ? (bongo_map_p0 & ~bongo_prev_p1) : 4'b0000;

  assign nes_go_p0        = (state_p1 == IDLE) && (|nes_edge_p0);
  assign bongo_go_p0      = (state_p1 == IDLE) && (|bongo_edge_p0) && !nes_go_p0;
  assign nes_turn_ok_p0   = (state_p1 == IDLE) || (state_p1 == NES_ACT);
  assign bongo_turn_ok_p0 = (state_p1 == BONGO_ACT) || bongo_go_p0;
  assign act_press_p0     = ((state_p1 == NES_ACT) && (|nes_edge_p0)) ||
                            ((state_p1 == BONGO_ACT) && (|bongo_edge_p0));
  assign timeout_p0       = (state_p1 != IDLE) && (int'(idle_cnt_p1) >= TIMEOUT_TICKS);

  always_comb begin
    turn_p0 = 3'b000;
    if (nes_turn_ok_p0 && (|nes_edge_p0[2:0]))
      turn_p0 = nes_edge_p0[2:0];
    else if (bongo_turn_ok_p0)
      turn_p0 = bongo_edge_p0[2:0];
  end

  // Stage p1: state, history, counters and the turn buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_p1 <= IDLE;
    else      state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE: begin
        if (nes_go_p0)        state_nxt = NES_ACT;
        else if (bongo_go_p0) state_nxt = BONGO_ACT;
      end
      NES_ACT, BONGO_ACT: if (timeout_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state_p1)
      NES_ACT:   active_src = 2'b01;
      BONGO_ACT: active_src = 2'b10;
      default:   active_src = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nes_prev_p1     <= 4'b0000;
      bongo_prev_p1   <= 4'b0000;
      nes_primed_p1   <= 1'b0;
      bongo_primed_p1 <= 1'b0;
      start           <= 1'b0;
    end else begin
      if (nes_valid) begin
        nes_prev_p1   <= nes_map_p0;
        nes_primed_p1 <= 1'b1;
      end
      if (bongo_valid) begin
        bongo_prev_p1   <= bongo_map_p0;
        bongo_primed_p1 <= 1'b1;
      end
      start <= nes_edge_p0[3] | bongo_edge_p0[3];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              idle_cnt_p1 <= 8'd0;
    else if ((state_p1 == IDLE) || timeout_p0 || act_press_p0) idle_cnt_p1 <= 8'd0;
    else if (tick)                                         idle_cnt_p1 <= sat_inc8(idle_cnt_p1);
  end

  // A fresh write wins over ack and over a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_p1  <= 3'b000;
      life_p1 <= 4'd0;
    end else if (|turn_p0) begin
      buf_p1  <= prio_turn(turn_p0);
      life_p1 <= 4'd0;
    end else if (turn_ack) begin
      buf_p1  <= 3'b000;
      life_p1 <= 4'd0;
    end else if (tick && (|buf_p1)) begin
      if (int'(life_p1) + 1 >= REQ_LIFE) begin
        buf_p1  <= 3'b000;
        life_p1 <= 4'd0;
      end else begin
        life_p1 <= life_p1 + 4'd1;
      end
    end
  end

  assign uturn = buf_p1[2];
  assign lturn = buf_p1[1];
  assign rturn = buf_p1[0];

endmodule

// File: doc/turn_arbiter.md
TURN_ARBITER -- requirements
Module: turn_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 180: idle ticks after which the active source is released.
REQ-002 SHALL have parameter REQ_LIFE, default 8: ticks a buffered turn request survives without ack.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle game-tick pulse.
- mode  in  1  1 = direction controls, 0 = rotation controls.
- pacman_dir  in  2  00 RT, 01 UP, 10 DN, 11 LT.
- nes_btns  in  8  NES frame, index 0..7.
- nes_valid  in  1  one-cycle pulse: new nes_btns frame.
- bongo_btns  in  16  bongo frame, index 0..15.
- bongo_mic  in  8  bongo microphone level.
- bongo_valid  in  1  one-cycle pulse: new bongo frame.
- turn_ack  in  1  game consumed the buffered turn.
- lturn, rturn, uturn  out  1 each  buffered turn request, level, at most one high.
- start  out  1  one-cycle start pulse.
- active_src  out  2  00 none, 01 NES, 10 bongo.

Function
REQ-004 SHALL run a state machine IDLE, NES_ACT, BONGO_ACT; reset state IDLE.
REQ-005 IDLE: valid frame with any mapped turn or start button pressed SHALL move to that source's ACT state next cycle; both in same cycle -> NES_ACT.
REQ-006 ACT states SHALL keep an 8-bit saturating idle counter: cleared on an active-source frame with any button pressed, +1 per tick otherwise; reaching TIMEOUT_TICKS -> IDLE next cycle, counter cleared.
REQ-007 Frames from the inactive source SHALL be ignored for turns while in an ACT state.
REQ-008 Direction-mode absolute buttons: NES up 4, down 5, left 6, right 7; bongo up 12, down 13, right 14, left 15.
REQ-009 Direction mode SHALL map absolute to relative: RT l=up r=down u=left; UP l=left r=right u=down; DN l=right r=left u=up; LT l=down r=up u=right.
REQ-010 Rotation mode: NES l=btn1, r=btn0, u=btn5; bongo l=btn4|btn6, r=btn5|btn7, u per REQ-019.
REQ-011 Only rising edges SHALL count: each source keeps its previous mapped frame; pressed = current & ~previous, updated on every valid frame of that source.
REQ-012 New request SHALL overwrite buffer 1 cycle after the valid pulse; multiple edges in one frame -> priority u > l > r.
REQ-013 Buffer SHALL hold with 4-bit life counter loaded to 0 on write, +1 per tick; reaching REQ_LIFE clears the buffer.
REQ-014 turn_ack SHALL clear the buffer next cycle; ack and new request in the same cycle -> new request wins.
REQ-015 tick coincident with a buffer write SHALL NOT increment the fresh life counter.
REQ-016 start SHALL pulse one cycle after a valid frame of any source (active or not) showing a rising edge on btn3.
REQ-017 Change of mode or pacman_dir SHALL NOT alter an already-buffered request.

Reset
REQ-018 rst low SHALL asynchronously force IDLE, active_src 00, lturn/rturn/uturn/start 0, all counters and previous-frame registers 0; release sampled on next rising clk.

Configuration
REQ-019 Macro MIC_UTURN_EN: defined -> bongo rotation-mode u = (bongo_mic > 64) & ~(l|r), edge-detected per REQ-011; undefined -> bongo rotation-mode u constant 0, bongo_mic unused.

Verification
REQ-020 Bench SHALL cover:
- IDLE, nes_valid with btn4 only, mode=1, dir=RT -> active_src 01, lturn=1 one cycle after pulse.
- Same cycle nes_valid btn7 and bongo_valid btn14 from IDLE -> active_src 01; bongo frames ignored afterwards.
- NES_ACT, 180 ticks no presses -> active_src 00; next bongo btn12 press -> 10.
- Buffered lturn, no ack, 8 ticks -> lturn 0 after 8th tick; turn_ack plus simultaneous new uturn edge -> uturn=1.
- mode=0, bongo_mic=0x50, no drums -> uturn=1 with MIC_UTURN_EN, 0 without.
- rst low mid-request -> all outputs 0 immediately; held btn4 after reset -> no request until released and re-pressed.
